// File: rtl/stream_rx_pkg.sv
// Shared types and widths for the stream receive checker.
// The optional parity check is enabled with STREAM_RX_PARITY_EN.
package stream_rx_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PASS,
        FAIL
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/stream_rx_fifo.sv
// Power-of-two circular FIFO with registered occupancy.
// Push is refused when full and pop when empty, so callers may drive raw requests.
module stream_rx_fifo
    import stream_rx_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/stream_rx_checker.sv
// Stream receiver: buffers beats, drains them into a checksum and judges pass/fail.
// Define STREAM_RX_PARITY_EN to add the in_parity input and its even-parity check.
module stream_rx_checker
    import stream_rx_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TARGET_TXNS = 16,
    parameter int TIMEOUT     = 64,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
`ifdef STREAM_RX_PARITY_EN
    input  logic              in_parity,
`endif
    output logic              in_ready,
    input  logic              drain_en,
    output logic [CNT_W-1:0]  rx_count,
    output logic [DATA_W-1:0] checksum,
    output logic              passed,
    output logic              failed
);

    state_e            state_q, state_d;
    logic              ready_en_q;
    logic              stall_q, stall_d;
    logic [DATA_W-1:0] prev_data_q;
    logic [CNT_W-1:0]  idle_q, idle_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sum_q, sum_d;

    logic              fifo_full, fifo_empty;
    logic [AW:0]       unused_fifo_count;
    logic [DATA_W-1:0] fifo_rdata;

    logic live, accept, pop_fire;
    logic stall_viol, timeout, reached;

    stream_rx_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (accept),
        .data_i  (in_data),
        .pop_i   (pop_fire),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (unused_fifo_count)
    );

    // ready_en_q holds in_ready low until the first edge after reset release.
    assign live     = (state_q == IDLE) || (state_q == RUN);
    assign in_ready = ready_en_q && live && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign pop_fire = drain_en && !fifo_empty;

    assign stall_viol = stall_q && (!in_valid || (in_data != prev_data_q));
    assign timeout    = (idle_q > CNT_W'(TIMEOUT));
    assign reached    = (cnt_q >= CNT_W'(TARGET_TXNS));

    assign rx_count = cnt_q;
    assign checksum = sum_q;
    assign passed   = (state_q == PASS);
    assign failed   = (state_q == FAIL);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN: begin
                if (timeout || stall_viol) state_d = FAIL;
                else if (reached)          state_d = PASS;
            end
            default: state_d = state_q;
        endcase
`ifdef STREAM_RX_PARITY_EN
        if (accept && (in_parity != ^in_data)) state_d = FAIL;
`endif
    end

    always_comb begin
        stall_d = in_valid && !in_ready;
        idle_d  = idle_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        if (accept)              idle_d = '0;
        else if (state_q == RUN) idle_d = sat_inc(idle_q);
        if (pop_fire) begin
            cnt_d = sat_inc(cnt_q);
            sum_d = sum_q + fifo_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ready_en_q  <= 1'b0;
            stall_q     <= 1'b0;
            prev_data_q <= '0;
            idle_q      <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_en_q  <= 1'b1;
            stall_q     <= stall_d;
            prev_data_q <= in_data;
            idle_q      <= idle_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
        end
    end

endmodule

// File: tb/tb_stream_rx_checker.sv
// Self-checking bench for stream_rx_checker: vector table, scoreboard, corner sequences.
// Parity sequences run only when STREAM_RX_PARITY_EN is defined.
module tb_stream_rx_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        drain_en = 1'b0;
    logic        in_ready;
    logic [15:0] rx_count;
    logic [7:0]  checksum;
    logic        passed;
    logic        failed;
`ifdef STREAM_RX_PARITY_EN
    logic        in_parity = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] prev_cnt = 16'd0;
    logic [7:0]  prev_cs = 8'd0;
    logic        acc = 1'b0;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        dr;
        logic        acc;
        logic [15:0] cnt;
        logic [7:0]  cs;
    } vec_t;

    vec_t tbl[13];

    always #5 clk = ~clk;

    stream_rx_checker #(
        .DEPTH(4),
        .TARGET_TXNS(16),
        .TIMEOUT(64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
`ifdef STREAM_RX_PARITY_EN
        .in_parity(in_parity),
`endif
        .in_ready (in_ready),
        .drain_en (drain_en),
        .rx_count (rx_count),
        .checksum (checksum),
        .passed   (passed),
        .failed   (failed)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One clock: note acceptance before the edge, then score any pop after it.
    task automatic tick();
        logic [7:0] e;
        logic [7:0] d;
        @(negedge clk);
        acc = reset && in_valid && in_ready;
        if (acc) exp_q.push_back(in_data);
        @(posedge clk);
        #1;
        if (!reset) begin
            exp_q.delete();
            prev_cnt = 16'd0;
            prev_cs = 8'd0;
        end else if (rx_count != prev_cnt) begin
            total++;
            if (rx_count != prev_cnt + 16'd1 || exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_pop: count %0d after %0d, queued %0d",
                         rx_count, prev_cnt, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                d = checksum - prev_cs;
                if (d !== e) begin
                    bad++;
                    $display("FAIL sb_data: popped %0h want %0h", d, e);
                end
            end
            prev_cnt = rx_count;
            prev_cs = checksum;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        drain_en = 1'b0;
        in_data = 8'h00;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 16'd0, 8'h00};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 16'd0, 8'h00};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 16'd0, 8'h00};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 16'd0, 8'h00};
        tbl[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 16'd0, 8'h00};
        tbl[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, 16'd0, 8'h00};
        tbl[6]  = '{1'b1, 8'h55, 1'b1, 1'b0, 16'd1, 8'h11};
        tbl[7]  = '{1'b1, 8'h55, 1'b1, 1'b1, 16'd2, 8'h33};
        tbl[8]  = '{1'b1, 8'h66, 1'b1, 1'b1, 16'd3, 8'h66};
        tbl[9]  = '{1'b0, 8'h66, 1'b1, 1'b0, 16'd4, 8'hAA};
        tbl[10] = '{1'b0, 8'h66, 1'b1, 1'b0, 16'd5, 8'hFF};
        tbl[11] = '{1'b0, 8'h66, 1'b1, 1'b0, 16'd6, 8'h65};
        tbl[12] = '{1'b0, 8'h66, 1'b1, 1'b0, 16'd6, 8'h65};

        // Reset state, beats offered during reset, ready release timing.
        reset = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h99;
        drain_en = 1'b1;
        tick();
        tick();
        check("rst_ready", in_ready, 0);
        check("rst_count", rx_count, 0);
        check("rst_cs", checksum, 0);
        check("rst_passed", passed, 0);
        check("rst_failed", failed, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("ready_at_release", in_ready, 0);
        tick();
        check("ready_after_edge", in_ready, 1);
        tick();
        check("no_beat_from_reset", rx_count, 0);

        // Full FIFO, stalled beat held stable, then ordered drain.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            in_valid = tbl[i].v;
            in_data = tbl[i].d;
            drain_en = tbl[i].dr;
            tick();
            check($sformatf("row%0d_acc", i), acc, tbl[i].acc);
            check($sformatf("row%0d_cnt", i), rx_count, tbl[i].cnt);
            check($sformatf("row%0d_cs", i), checksum, tbl[i].cs);
            check($sformatf("row%0d_failed", i), failed, 0);
        end
        check("full_sb_empty", exp_q.size(), 0);

        // Basic pass: 1..16 streamed with continuous drain.
        do_reset();
        drain_en = 1'b1;
        in_valid = 1'b1;
        n = 1;
        in_data = 8'd1;
        for (int c = 0; c < 200 && !passed; c++) begin
            tick();
            if (acc) begin
                n++;
                if (n > 16) in_valid = 1'b0;
                else in_data = 8'(n);
            end
        end
        check("pass_passed", passed, 1);
        check("pass_failed", failed, 0);
        check("pass_count", rx_count, 16);
        check("pass_cs", checksum, 8'h88);
        check("pass_beats", n, 17);
        check("pass_ready", in_ready, 0);
        tick();
        tick();
        check("pass_sticky", passed, 1);

        // Stall violation: data changes while held off by a full FIFO.
        do_reset();
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_data = 8'hA5;
        tick();
        check("stall_acc", acc, 0);
        check("stall_not_yet", failed, 0);
        in_data = 8'h5A;
        tick();
        check("stall_failed", failed, 1);
        check("stall_passed", passed, 0);
        check("stall_ready", in_ready, 0);
        in_valid = 1'b0;
        drain_en = 1'b1;
        repeat (6) tick();
        check("fail_drain_cnt", rx_count, 4);
        check("fail_drain_cs", checksum, 8'h0A);
        check("fail_sticky", failed, 1);

        // Timeout: one beat, then silence.
        do_reset();
        drain_en = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h42;
        tick();
        check("to_acc", acc, 1);
        in_valid = 1'b0;
        repeat (64) tick();
        check("to_edge_ok", failed, 0);
        tick();
        tick();
        check("to_failed", failed, 1);
        check("to_passed", passed, 0);

        // Reset mid-run after 10 beats.
        do_reset();
        drain_en = 1'b1;
        in_valid = 1'b1;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            in_data = 8'(i);
            tick();
            if (acc) n++;
        end
        check("mid_beats", n, 10);
        reset = 1'b0;
        #1;
        check("mid_cnt", rx_count, 0);
        check("mid_cs", checksum, 0);
        check("mid_ready", in_ready, 0);
        check("mid_flags", {passed, failed}, 0);
        in_data = 8'hEE;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        check("mid_empty", rx_count, 0);
        in_valid = 1'b1;
        in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_new_cnt", rx_count, 1);
        check("mid_new_cs", checksum, 8'h77);

`ifdef STREAM_RX_PARITY_EN
        do_reset();
        in_valid = 1'b1;
        in_data = 8'h03;
        in_parity = 1'b1;
        tick();
        in_valid = 1'b0;
        check("par_bad_failed", failed, 1);
        do_reset();
        drain_en = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h03;
        in_parity = 1'b0;
        tick();
        check("par_ok_acc", acc, 1);
        in_valid = 1'b0;
        tick();
        tick();
        check("par_ok_failed", failed, 0);
        check("par_ok_cnt", rx_count, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
